// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display driver and its readback decoder:
// segment encodings (active-low, bit7 = dp, bits6:0 = g..a), the digit code
// type and the decoder FSM states.
package hex_display_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h98;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {
        SETTLE,
        HOLD,
        WAIT_CHANGE
    } dec_state_t;

    // Digit code shared with the display driver: blank flag above the nibble.
    typedef struct packed {
        logic       blank;
        logic [3:0] nibble;
    } digit_code_t;

    // Segment pattern the driver emits for a hex nibble.
    function automatic logic [7:0] nibble_to_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_display_decoder_seg_to_nibble.sv
// Combinational exact-match decode of one 7-segment byte into a digit code.
// Blank and minus are recognised separately; anything else outside the
// sixteen hex glyphs is flagged illegal.
module seg_to_nibble
    import hex_display_pkg::*;
(
    input  logic [7:0]  seg,
    output digit_code_t code,
    output logic        minus,
    output logic        illegal
);

    // Match the byte against every glyph; no partial or dp-tolerant matches.
    always_comb begin
        code.blank  = (seg == SEG_BLANK);
        code.nibble = 4'h0;
        minus       = (seg == SEG_MINUS);
        illegal     = !(code.blank || minus);
        for (int i = 0; i < 16; i++) begin
            if (seg == nibble_to_seg(4'(i))) begin
                code.nibble = 4'(i);
                illegal     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hex_display_decoder.sv
// Readback monitor for the six-digit hex display. Captures the segment
// buses, waits for STABLE_CYCLES unchanged cycles, decodes the pattern and
// reports each new stable value once over a valid/ready handshake.
// Optional build macro HEX_DECODER_MINUS_SIGN_EN accepts a minus on hex3
// and reports it on out_neg; without it out_neg is tied low.
module hex_display_decoder
    import hex_display_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hex5,
    input  logic [7:0] hex4,
    input  logic [7:0] hex3,
    input  logic [7:0] hex2,
    input  logic [7:0] hex1,
    input  logic [7:0] hex0,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [9:0] out_value,
    output logic       out_err,
    output logic       out_neg
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [47:0] pat_in;
    logic [47:0] p_p0;
    logic [47:0] last_p;
    logic [7:0]  cnt;
    logic        have_reported;
    dec_state_t  state;
    dec_state_t  state_d;
    logic        load;
    logic        leave_hold;
    logic        stable_hit;

    digit_code_t code   [6];
    logic        minus  [6];
    logic        illegal[6];
    logic        shown  [6];

    logic        err_c;
    logic [9:0]  value_c;
    logic        neg_c;

    assign pat_in     = {hex5, hex4, hex3, hex2, hex1, hex0};
    assign stable_hit = (pat_in == p_p0) && (cnt == CNT_MAX);
    assign out_valid  = (state == HOLD);

    // Capture stage: register the raw segment buses every cycle.
    always_ff @(posedge clk) begin
        if (rst) p_p0 <= '1;
        else     p_p0 <= pat_in;
    end

    // Stability counter: restarts on any change and when a report is consumed.
    always_ff @(posedge clk) begin
        if (rst)                               cnt <= 8'd0;
        else if (pat_in != p_p0 || leave_hold) cnt <= 8'd0;
        else if (cnt != CNT_MAX)               cnt <= cnt + 8'd1;
    end

    for (genvar g = 0; g < 6; g++) begin : g_dig
        seg_to_nibble u_dec (
            .seg     (p_p0[8*g +: 8]),
            .code    (code[g]),
            .minus   (minus[g]),
            .illegal (illegal[g])
        );
        assign shown[g] = !code[g].blank && !minus[g] && !illegal[g];
    end

    // Legality of the captured pattern as the display driver could produce it.
    always_comb begin
        err_c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (illegal[i]) err_c = 1'b1;
        end
        if (!code[5].blank || !code[4].blank) err_c = 1'b1;
`ifdef HEX_DECODER_MINUS_SIGN_EN
        if (!code[3].blank && !minus[3]) err_c = 1'b1;
        if (minus[3] && code[2].blank && code[1].blank && code[0].blank) err_c = 1'b1;
`else
        if (!code[3].blank) err_c = 1'b1;
`endif
        if (!(code[2].blank || (shown[2] && code[2].nibble >= 4'd1 && code[2].nibble <= 4'd3)))
            err_c = 1'b1;
        if (!(shown[1] || (code[1].blank && code[2].blank))) err_c = 1'b1;
        if (!shown[0]) err_c = 1'b1;
        // Blank digits decode to nibble 0, so they contribute nothing.
        value_c = err_c ? 10'd0 : {code[2].nibble[1:0], code[1].nibble, code[0].nibble};
`ifdef HEX_DECODER_MINUS_SIGN_EN
        neg_c = minus[3] && !err_c;
`else
        neg_c = 1'b0;
`endif
    end

    // Next-state logic for the settle / hold / wait-for-change sequence.
    always_comb begin
        state_d    = state;
        load       = 1'b0;
        leave_hold = 1'b0;
        case (state)
            SETTLE: begin
                if (stable_hit) begin
                    if (!have_reported || p_p0 != last_p) begin
                        state_d = HOLD;
                        load    = 1'b1;
                    end else begin
                        state_d = WAIT_CHANGE;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d    = SETTLE;
                    leave_hold = 1'b1;
                end
            end
            WAIT_CHANGE: begin
                if (p_p0 != last_p) state_d = SETTLE;
            end
            default: state_d = SETTLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= SETTLE;
        else     state <= state_d;
    end

    // Report registers: frozen while a report is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_reported <= 1'b0;
            last_p        <= '1;
            out_value     <= 10'd0;
            out_err       <= 1'b0;
            out_neg       <= 1'b0;
        end else if (load) begin
            have_reported <= 1'b1;
            last_p        <= p_p0;
            out_value     <= value_c;
            out_err       <= err_c;
            out_neg       <= neg_c;
        end
    end

endmodule

// File: tb/tb_hex_display_decoder.sv
// Directed bench for hex_display_decoder with default STABLE_CYCLES = 4.
// Honors HEX_DECODER_MINUS_SIGN_EN for the minus-sign expectations.
module tb_hex_display_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] out_value;
    logic       out_err;
    logic       out_neg;

    int n_cmp = 0;
    int n_bad = 0;

    hex_display_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .hex5      (hex5),
        .hex4      (hex4),
        .hex3      (hex3),
        .hex2      (hex2),
        .hex1      (hex1),
        .hex0      (hex0),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_value (out_value),
        .out_err   (out_err),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [47:0] pat);
        {hex5, hex4, hex3, hex2, hex1, hex0} = pat;
    endtask

    // Edges until out_valid is seen, counting the first edge after the call as 1.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat;
    int nv;
    logic [9:0] seen_val;

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(48'hFFFF_FFFF_FFFF);
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_value", 32'(out_value), 32'd0);
        chk("rst_err",   32'(out_err),   32'd0);
        chk("rst_neg",   32'(out_neg),   32'd0);

        // 1: 2,0,E shown
        rst = 1'b0;
        drive(48'hFFFF_FFA4_C086);
        wait_valid(lat);
        chk("t1_lat",   32'(lat),       32'd5);
        chk("t1_value", 32'(out_value), 32'h20E);
        chk("t1_err",   32'(out_err),   32'd0);
        step();
        chk("t1_pulse", 32'(out_valid), 32'd0);
        repeat (8) step();

        // 2: value frozen during HOLD, later change re-reported
        out_ready = 1'b0;
        drive(48'hFFFF_FFFF_FFF9);
        wait_valid(lat);
        chk("t2_lat",   32'(lat),       32'd5);
        chk("t2_value", 32'(out_value), 32'h001);
        repeat (3) step();
        drive(48'hFFFF_FFFF_FFA4);
        repeat (6) step();
        chk("t2_hold_valid", 32'(out_valid), 32'd1);
        chk("t2_hold_value", 32'(out_value), 32'h001);
        out_ready = 1'b1;
        wait_valid(lat);
        chk("t2_relat",   32'(lat),       32'd5);
        chk("t2_revalue", 32'(out_value), 32'h002);
        repeat (8) step();

        // 3: toggling every 3 cycles never settles
        nv = 0;
        for (int t = 0; t < 8; t++) begin
            drive((t % 2 == 0) ? 48'hFFFF_FFFF_FFC0 : 48'hFFFF_FFFF_FFF9);
            repeat (3) begin
                step();
                if (out_valid) nv++;
            end
        end
        chk("t3_toggle_reports", 32'(nv), 32'd0);
        drive(48'hFFFF_FFFF_FFF9);
        nv = 0;
        seen_val = 10'h3FF;
        repeat (20) begin
            step();
            if (out_valid) begin
                nv++;
                seen_val = out_value;
            end
        end
        chk("t3_reports", 32'(nv),       32'd1);
        chk("t3_value",   32'(seen_val), 32'h001);
        repeat (4) step();

        // 4: leading zero shown, then a digit on hex4
        out_ready = 1'b0;
        drive(48'hFFFF_FFC0_F9C0);
        wait_valid(lat);
        chk("t4_lat",   32'(lat),       32'd5);
        chk("t4_err",   32'(out_err),   32'd1);
        chk("t4_value", 32'(out_value), 32'd0);
        out_ready = 1'b1;
        step();
        chk("t4_ack", 32'(out_valid), 32'd0);
        drive(48'hFFC0_FFFF_FFF9);
        wait_valid(lat);
        chk("t4b_err",   32'(out_err),   32'd1);
        chk("t4b_value", 32'(out_value), 32'd0);
        repeat (8) step();

        // 5: no repeat report for a held pattern; reset discards HOLD
        drive(48'hFFFF_FFFF_F992);
        wait_valid(lat);
        chk("t5_value", 32'(out_value), 32'h015);
        nv = 0;
        repeat (50) begin
            step();
            if (out_valid) nv++;
        end
        chk("t5_repeat", 32'(nv), 32'd0);
        out_ready = 1'b0;
        drive(48'hFFFF_FFFF_FF80);
        wait_valid(lat);
        chk("t5_hold_value", 32'(out_value), 32'h008);
        rst = 1'b1;
        step();
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_value", 32'(out_value), 32'd0);
        rst = 1'b0;
        wait_valid(lat);
        chk("t5_rerep_lat",   32'(lat),       32'd5);
        chk("t5_rerep_value", 32'(out_value), 32'h008);
        out_ready = 1'b1;
        repeat (8) step();

        // 6: minus on hex3
        drive(48'hFFFF_BFFF_F9C0);
        wait_valid(lat);
        chk("t6_lat", 32'(lat), 32'd5);
`ifdef HEX_DECODER_MINUS_SIGN_EN
        chk("t6_neg",   32'(out_neg),   32'd1);
        chk("t6_value", 32'(out_value), 32'h010);
        chk("t6_err",   32'(out_err),   32'd0);
`else
        chk("t6_neg",   32'(out_neg),   32'd0);
        chk("t6_value", 32'(out_value), 32'd0);
        chk("t6_err",   32'(out_err),   32'd1);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
